id_hazard_scoreboard: RTL and testbench
=======================================

Name: id_hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the decode stage of the MIPS pipeline.
- Replaces the ad-hoc combinational load-use check and fixed EX/MEM/WB forwarding priority with a tracked window of in-flight writers.
- Handles configurable pipeline depth and load-data-ready stage, plus a multi-cycle HI/LO busy counter for mult/div.
- Sits beside the ID stage: consumes decoded source/destination fields and drives `stallreq` and forwarding-mux selects.

Parameters:
- AW, 5, register address width; the register file holds 2**AW entries, and register 0 is hardwired to zero.
- DEPTH, 3, number of post-ID stages tracked (1=EX, 2=MEM, 3=WB).
- LOAD_READY, 2, first stage index at which load data can be forwarded.
- MD_LAT, 4, cycles HI/LO stays busy after mult/multu/div/divu issue, range 1..15.
- SW, 2, select width; must satisfy 2**SW > DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset: active-low and synchronous (low at a rising clk edge resets)
- pipe_adv_i  in  1  ID->EX boundary advances this cycle (stall[2]==NoStop)
- flush_i  in  1  kill the ID instruction; insert a bubble on advance
- id_valid_i  in  1  ID holds a valid instruction
- rs_ren_i, rt_ren_i  in  1 each  source read enables
- rs_i, rt_i  in  AW each  source addresses
- id_we_i  in  1  instruction writes the register file
- id_waddr_i  in  AW  destination address
- id_is_load_i  in  1  load instruction
- id_is_md_i  in  1  mult/multu/div/divu
- id_rd_hilo_i  in  1  mfhi/mflo
- stallreq_o  out  1  hold IF/ID
- fwd_rs_sel_o, fwd_rt_sel_o  out  SW each  0 = regfile value, k = result of stage k
- hilo_busy_o  out  1  HI/LO result still pending

Behaviour:
- State:
  - DEPTH records {v, we, waddr, ld}; record[k-1] represents stage k.
  - md_cnt counter, 4 bits.
- Reset (rst low at a clk edge): all records cleared, md_cnt=0.
- Outputs during and after reset until the ID inputs change: stallreq_o=0, both sel=0, hilo_busy_o=0.
- issue = id_valid_i & ~stallreq_o & ~flush_i.
- On clk with pipe_adv_i=1:
  - record[0] <= issue ? {1, id_we_i, id_waddr_i, id_is_load_i} : 0.
  - record[k] <= record[k-1] for k >= 1; the oldest record drops out.
- On clk with pipe_adv_i=0: all records hold.
- Source match for source s (rs or rt) with ren=1 and addr!=0:
  - Find the smallest k with record[k-1].v & we & waddr==addr; the youngest writer wins.
  - If no match, or ren=0, or addr=0: sel=0 and no hazard.
  - If matched and record.ld=1 with k<LOAD_READY: load-use hazard.
  - Otherwise: sel=k.
- hilo_busy_o = (md_cnt!=0).
- md_cnt update per clk:
  - If issue & id_is_md_i & pipe_adv_i: md_cnt <= MD_LAT.
  - Else if md_cnt!=0: decrement. The counter runs independently of pipe_adv_i.
- stallreq_o = id_valid_i & ~flush_i & (load-use hazard on rs or rt | (id_rd_hilo_i | id_is_md_i) & hilo_busy_o).
- stallreq_o is purely combinational from the current state and inputs: zero latency, no glitch requirement beyond single-cycle settling.
- Sel outputs are valid whenever id_valid_i=1; otherwise they are don't-care but must be driven to 0.
- Simultaneous events:
  - Flush with hazard: flush wins, stallreq_o=0, and a bubble is inserted.
  - Stall with pipe_adv_i=1: a bubble is inserted and the ID instruction is re-evaluated next cycle against the shifted window.
  - Writer to register 0: never matches.
  - Two records with the same waddr: the younger one wins.
- Reset mid-operation discards all in-flight records and the counter.

Decomposition:
- Shared package (lib/defines.vh):
  - hazard record field widths.
  - FWD_SEL_RF=0 constant.
  - MD_LAT default.
- Sub-module: id_src_match, instantiated twice (rs, rt).
  - Inputs: address and enable.
  - Outputs: sel and load-use flag.
  - Implemented as a priority scan over the records.

Test Plan:
- addiu $3 then addu $4,$3,$3 with continuous advance -> fwd_rs_sel=fwd_rt_sel=1, stallreq=0. One cycle later the same reader gives sel=2.
- lw $5 then addu $6,$5,$0 (LOAD_READY=2) -> stallreq=1 for one cycle and a bubble is inserted; next cycle fwd_rs_sel=2, fwd_rt_sel=0, stallreq=0.
- ori $7 in stage 3 and addiu $7 in stage 1, reader of $7 -> sel=1 (youngest wins).
- Writer to $0 followed by a reader of $0 -> sel=0, stallreq=0.
- mult then mfhi immediately (MD_LAT=4) -> hilo_busy=1 and stallreq=1 for 4 cycles; mfhi issues on the 5th cycle.
- lw $5 in stage 1, a reader of $5, and flush_i=1 in the same cycle -> stallreq=0 and the record inserted is a bubble. Separately, rst low with a record pending -> all sel outputs 0 on the next cycle.

Source files
------------

// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared widths and defaults for the ID-stage hazard scoreboard.
// Imported by the match unit, the interface users and the top.
package id_hazard_scoreboard_pkg;

    localparam int HZ_AW         = 5;
    localparam int HZ_DEPTH      = 3;
    localparam int HZ_LOAD_READY = 2;
    localparam int HZ_SW         = 2;
    localparam int MD_LAT_DEF    = 4;
    localparam int MD_CNT_W      = 4;
    localparam int FWD_SEL_RF    = 0;

    typedef logic [MD_CNT_W-1:0] md_cnt_t;

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// ID-stage <-> scoreboard bundle: decoded fields in, stall/select out.
// master = decode stage, slave = scoreboard.
interface id_hazard_scoreboard_if #(
    parameter int AW = 5,
    parameter int SW = 2
);
    logic          pipe_adv_i;
    logic          flush_i;
    logic          id_valid_i;
    logic          rs_ren_i;
    logic          rt_ren_i;
    logic [AW-1:0] rs_i;
    logic [AW-1:0] rt_i;
    logic          id_we_i;
    logic [AW-1:0] id_waddr_i;
    logic          id_is_load_i;
    logic          id_is_md_i;
    logic          id_rd_hilo_i;
    logic          stallreq_o;
    logic [SW-1:0] fwd_rs_sel_o;
    logic [SW-1:0] fwd_rt_sel_o;
    logic          hilo_busy_o;

    modport master (
        output pipe_adv_i, flush_i, id_valid_i,
        output rs_ren_i, rt_ren_i, rs_i, rt_i,
        output id_we_i, id_waddr_i, id_is_load_i,
        output id_is_md_i, id_rd_hilo_i,
        input  stallreq_o, fwd_rs_sel_o, fwd_rt_sel_o,
        input  hilo_busy_o
    );

    modport slave (
        input  pipe_adv_i, flush_i, id_valid_i,
        input  rs_ren_i, rt_ren_i, rs_i, rt_i,
        input  id_we_i, id_waddr_i, id_is_load_i,
        input  id_is_md_i, id_rd_hilo_i,
        output stallreq_o, fwd_rs_sel_o, fwd_rt_sel_o,
        output hilo_busy_o
    );

endinterface

// File: rtl/id_hazard_scoreboard_src_match.sv
// Priority scan of the in-flight writer window for one source operand.
// Returns the forwarding stage or flags a load-use hazard.
module id_src_match
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int AW         = HZ_AW,
    parameter int DEPTH      = HZ_DEPTH,
    parameter int LOAD_READY = HZ_LOAD_READY,
    parameter int SW         = HZ_SW
) (
    input  logic             ren,
    input  logic [AW-1:0]    addr,
    input  logic [DEPTH-1:0] rec_v,
    input  logic [DEPTH-1:0] rec_we,
    input  logic [DEPTH-1:0] rec_ld,
    input  logic [AW-1:0]    rec_waddr [DEPTH],
    output logic [SW-1:0]    sel,
    output logic             load_use
);

    logic          hit;
    logic          hit_ld;
    logic [SW-1:0] hit_k;
    logic          active;

    // Oldest to youngest, so the youngest matching writer overwrites.
    always_comb begin
        hit    = 1'b0;
        hit_ld = 1'b0;
        hit_k  = SW'(FWD_SEL_RF);
        for (int k = DEPTH; k >= 1; k--) begin
            if (rec_v[k-1] && rec_we[k-1]
                && rec_waddr[k-1] == addr) begin
                hit    = 1'b1;
                hit_ld = rec_ld[k-1];
                hit_k  = SW'(k);
            end
        end
    end

    always_comb begin
        active   = ren && (addr != '0) && hit;
        load_use = active && hit_ld
                   && (int'(hit_k) < LOAD_READY);
        sel      = (active && !load_use)
                   ? hit_k : SW'(FWD_SEL_RF);
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard/forwarding controller over a window of in-flight
// writers, plus a HI/LO busy countdown for mult/div.
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int AW         = HZ_AW,
    parameter int DEPTH      = HZ_DEPTH,
    parameter int LOAD_READY = HZ_LOAD_READY,
    parameter int MD_LAT     = MD_LAT_DEF,
    parameter int SW         = HZ_SW
) (
    input logic                   clk,
    input logic                   rst,
    id_hazard_scoreboard_if.slave hz
);

    logic [DEPTH-1:0] rec_v;
    logic [DEPTH-1:0] rec_we;
    logic [DEPTH-1:0] rec_ld;
    logic [AW-1:0]    rec_waddr [DEPTH];
    md_cnt_t          md_cnt;

    logic [SW-1:0] rs_sel;
    logic [SW-1:0] rt_sel;
    logic          rs_lu;
    logic          rt_lu;
    logic          busy;
    logic          stall;
    logic          issue;

    id_src_match #(
        .AW(AW), .DEPTH(DEPTH),
        .LOAD_READY(LOAD_READY), .SW(SW)
    ) u_rs (
        .ren(hz.rs_ren_i), .addr(hz.rs_i),
        .rec_v(rec_v), .rec_we(rec_we),
        .rec_ld(rec_ld), .rec_waddr(rec_waddr),
        .sel(rs_sel), .load_use(rs_lu)
    );

    id_src_match #(
        .AW(AW), .DEPTH(DEPTH),
        .LOAD_READY(LOAD_READY), .SW(SW)
    ) u_rt (
        .ren(hz.rt_ren_i), .addr(hz.rt_i),
        .rec_v(rec_v), .rec_we(rec_we),
        .rec_ld(rec_ld), .rec_waddr(rec_waddr),
        .sel(rt_sel), .load_use(rt_lu)
    );

    // Flush overrides any hazard; a killed instruction never stalls.
    always_comb begin
        busy  = (md_cnt != '0);
        stall = hz.id_valid_i && !hz.flush_i
                && (rs_lu || rt_lu
                    || ((hz.id_rd_hilo_i || hz.id_is_md_i) && busy));
        issue = hz.id_valid_i && !stall && !hz.flush_i;
    end

    assign hz.stallreq_o   = stall;
    assign hz.hilo_busy_o  = busy;
    assign hz.fwd_rs_sel_o = hz.id_valid_i ? rs_sel : SW'(FWD_SEL_RF);
    assign hz.fwd_rt_sel_o = hz.id_valid_i ? rt_sel : SW'(FWD_SEL_RF);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rec_v  <= '0;
            rec_we <= '0;
            rec_ld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rec_waddr[k] <= '0;
            end
        end else if (hz.pipe_adv_i) begin
            rec_v[0]     <= issue;
            rec_we[0]    <= issue && hz.id_we_i;
            rec_ld[0]    <= issue && hz.id_is_load_i;
            rec_waddr[0] <= issue ? hz.id_waddr_i : '0;
            for (int k = 1; k < DEPTH; k++) begin
                rec_v[k]     <= rec_v[k-1];
                rec_we[k]    <= rec_we[k-1];
                rec_ld[k]    <= rec_ld[k-1];
                rec_waddr[k] <= rec_waddr[k-1];
            end
        end
    end

    // Countdown ignores pipe_adv: the divider keeps running under stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            md_cnt <= '0;
        end else if (issue && hz.id_is_md_i && hz.pipe_adv_i) begin
            md_cnt <= md_cnt_t'(MD_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench: stimulus pushes expected outputs, a negedge monitor
// pops and compares them against the scoreboard outputs.
module tb_id_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    id_hazard_scoreboard_if #(.AW(5), .SW(2)) bus ();

    id_hazard_scoreboard #(
        .AW(5), .DEPTH(3), .LOAD_READY(2), .MD_LAT(4), .SW(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz(bus)
    );

    typedef struct packed {
        int         id;
        logic       stall;
        logic [1:0] rs_sel;
        logic [1:0] rt_sel;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    task automatic chk(input string nm, input int id,
                       input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL vec%0d %s: got %0d expected %0d",
                     id, nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stallreq", e.id, int'(bus.stallreq_o), int'(e.stall));
            chk("rs_sel", e.id, int'(bus.fwd_rs_sel_o), int'(e.rs_sel));
            chk("rt_sel", e.id, int'(bus.fwd_rt_sel_o), int'(e.rt_sel));
            chk("hilo_busy", e.id, int'(bus.hilo_busy_o), int'(e.busy));
        end
    end

    // One ID cycle: r adv flush valid | rsen rten rs rt | we wa ld md hilo
    // followed by the expected stall, rs_sel, rt_sel, busy.
    task automatic step(
        input int r, input int adv, input int fl, input int vld,
        input int rse, input int rte, input int rs, input int rt,
        input int we, input int wa, input int ld, input int md,
        input int hl,
        input int e_st, input int e_rs, input int e_rt, input int e_bz
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r[0];
        bus.pipe_adv_i   = adv[0];
        bus.flush_i      = fl[0];
        bus.id_valid_i   = vld[0];
        bus.rs_ren_i     = rse[0];
        bus.rt_ren_i     = rte[0];
        bus.rs_i         = 5'(rs);
        bus.rt_i         = 5'(rt);
        bus.id_we_i      = we[0];
        bus.id_waddr_i   = 5'(wa);
        bus.id_is_load_i = ld[0];
        bus.id_is_md_i   = md[0];
        bus.id_rd_hilo_i = hl[0];
        e.id     = vec_id;
        e.stall  = e_st[0];
        e.rs_sel = 2'(e_rs);
        e.rt_sel = 2'(e_rt);
        e.busy   = e_bz[0];
        exp_q.push_back(e);
        vec_id++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pipe_adv_i   = 1'b0;
        bus.flush_i      = 1'b0;
        bus.id_valid_i   = 1'b0;
        bus.rs_ren_i     = 1'b0;
        bus.rt_ren_i     = 1'b0;
        bus.rs_i         = '0;
        bus.rt_i         = '0;
        bus.id_we_i      = 1'b0;
        bus.id_waddr_i   = '0;
        bus.id_is_load_i = 1'b0;
        bus.id_is_md_i   = 1'b0;
        bus.id_rd_hilo_i = 1'b0;

        // reset
        step(0,1,0,0, 0,0,0,0, 0,0,0,0,0,  0,0,0,0);
        step(0,1,0,0, 0,0,0,0, 0,0,0,0,0,  0,0,0,0);
        // addiu $3 ; readers of $3 walk through stages 1,2,3 then gone
        step(1,1,0,1, 1,0,0,0, 1,3,0,0,0,  0,0,0,0);
        step(1,1,0,1, 1,1,3,3, 1,4,0,0,0,  0,1,1,0);
        step(1,1,0,1, 1,1,3,3, 1,9,0,0,0,  0,2,2,0);
        step(1,1,0,1, 1,1,3,3, 1,9,0,0,0,  0,3,3,0);
        step(1,1,0,1, 1,1,3,3, 1,9,0,0,0,  0,0,0,0);
        // lw $5 ; addu $6,$5,$0 stalls once, then forwards from stage 2
        step(1,1,0,1, 1,0,29,0, 1,5,1,0,0, 0,0,0,0);
        step(1,1,0,1, 1,1,5,0, 1,6,0,0,0,  1,0,0,0);
        step(1,1,0,1, 1,1,5,0, 1,6,0,0,0,  0,2,0,0);
        // ori $7 (stage 3) vs addiu $7 (stage 1): youngest wins
        step(1,1,0,1, 1,0,0,0, 1,7,0,0,0,  0,0,0,0);
        step(1,1,0,1, 0,0,0,0, 1,10,0,0,0, 0,0,0,0);
        step(1,1,0,1, 1,0,0,0, 1,7,0,0,0,  0,0,0,0);
        step(1,1,0,1, 1,1,7,7, 0,0,0,0,0,  0,1,1,0);
        // writer to $0 then reader of $0
        step(1,1,0,1, 0,0,0,0, 1,0,0,0,0,  0,0,0,0);
        step(1,1,0,1, 1,1,0,0, 0,0,0,0,0,  0,0,0,0);
        // mult then mfhi: 4 stalled cycles, issues on the 5th
        step(1,1,0,1, 1,1,2,3, 0,0,0,1,0,  0,0,0,0);
        for (int i = 0; i < 4; i++)
            step(1,1,0,1, 0,0,0,0, 1,11,0,0,1, 1,0,0,1);
        step(1,1,0,1, 0,0,0,0, 1,11,0,0,1, 0,0,0,0);
        // mult, then the counter drains while the pipe is frozen
        step(1,1,0,1, 1,1,2,3, 0,0,0,1,0,  0,0,0,0);
        for (int i = 0; i < 4; i++)
            step(1,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0,1);
        step(1,1,0,0, 0,0,0,0, 0,0,0,0,0,  0,0,0,0);
        // lw $5 ; flushed addu $5,$5,$0 must leave a bubble
        step(1,1,0,1, 1,0,29,0, 1,5,1,0,0, 0,0,0,0);
        step(1,1,1,1, 1,1,5,0, 1,5,0,0,0,  0,0,0,0);
        step(1,1,0,1, 1,1,5,5, 1,14,0,0,0, 0,2,2,0);
        // addiu $13 ; reset while a mult reading $13 sits in ID
        step(1,1,0,1, 1,0,0,0, 1,13,0,0,0, 0,0,0,0);
        step(0,1,0,1, 1,0,13,0, 0,0,0,1,0, 0,1,0,0);
        step(1,1,0,1, 1,1,13,13, 0,0,0,0,1, 0,0,0,0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0",
                     exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
